huffman_code_ctrl: RTL and testbench
====================================

Name: huffman_code_ctrl

Overview:
- Sequencer for the Huffman combine phase. It is started once the CNT1..CNT6 symbol counts are valid.
- Runs 5 iterative merge rounds over 6 symbol groups using a single shared comparator, scanning one group per cycle.
- Builds the per-symbol Huffman code (HC) and mask (M) and pulses code_valid when they are complete.
- Sits downstream of the counting/sorting stage and drives the top-level HC1..HC6 / M1..M6 outputs.

Parameters:
- CW, 8, width of each input count; internal group weight width is CW+3.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request; CNT1..CNT6 are sampled on the same edge
- CNT1..CNT6  input  CW each  occurrence counts of symbols 1..6
- busy  output  1  high from the LOAD state through the DONE state
- code_valid  output  1  one-cycle pulse when HC/M are final
- HC1..HC6  output  8 each  Huffman code of symbol n, right-aligned
- M1..M6  output  8 each  mask of symbol n, equal to (1<<len)-1

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, code_valid=0, all HC/M=0, all internal registers cleared. Reset mid-operation aborts the run; after release the block waits in IDLE.
- Per-symbol state: group id g[n] (initially n), weight w[g] (CW+3 bits, zero-extended CNT), active[g] flag, code c[n] (8b), length len[n] (3b).
- FSM transitions:
  - IDLE: start=1 moves to LOAD. start is ignored in every other state.
  - LOAD (1 cycle): load weights, set all groups active, clear c/len/HC/M, round=0, busy=1.
  - SCAN (6 cycles, idx 0..5): min1/min2 trackers start at weight all-ones. For each active group idx:
    - if w<w_min1: min2<=min1, min1<=idx;
    - else if w<w_min2: min2<=idx.
    - Strict compares, so on equal weights the lower group index ranks as smaller. Inactive groups are skipped.
  - MERGE (1 cycle):
    - Every symbol n with g[n]==min1: c[n] |= 1<<len[n], len[n]++.
    - Every symbol n with g[n]==min2: bit 0 at position len[n], len[n]++.
    - New group id = lower of min1/min2; w[new] = w[min1]+w[min2]; the other id is deactivated and all its members are reassigned.
    - round++. If round==5, go to DONE; otherwise go to SCAN.
  - DONE (1 cycle): HCn<=c[n], Mn<=(1<<len[n])-1, code_valid=1, busy=0 next cycle, return to IDLE.
- Latency, with the start edge as cycle 0:
  - LOAD in cycle 1; round k has SCAN in cycles 2+7k..7+7k and MERGE in cycle 8+7k (k=0..4).
  - code_valid and the final HC/M are registered outputs, high/updated in cycle 37; total 37 cycles start-to-valid.
- Widths: max length is 5, so codes fit in 8 bits. Maximum sum is 6*(2^CW-1); CW+3 bits cannot overflow.
- Zero counts: symbols with CNT=0 participate normally with weight 0.
- HC/M hold their values until the next LOAD, which clears them to 0. code_valid is high for exactly one cycle per run.
- start asserted in the same cycle as code_valid: ignored (state is DONE). start in the following cycle: accepted.

Test Plan:
- Reset: reset=0 at any time -> busy=0, code_valid=0, all HC/M=0x00; a run aborted at cycle 20 produces no code_valid.
- Distinct weights: CNT=10,20,30,40,50,60 -> code_valid at cycle 37 with:
  - HC=0x07,0x06,0x02,0x03,0x02,0x00
  - M=0x0F,0x0F,0x07,0x03,0x03,0x03
- All-equal ties: CNT=1,1,1,1,1,1 -> HC=0x03,0x02,0x01,0x00,0x03,0x02; M=0x07,0x07,0x07,0x07,0x03,0x03.
- Busy protocol: start pulsed at cycles 0, 5 and 37 -> single code_valid at 37, busy high 1..37, no restart; start at 38 -> second run, code_valid at 75.
- Zero/max counts:
  - CNT=0,0,0,0,0,255 (CW=8) -> M6=0x01, HC6=0x00, no overflow.
  - CNT=255 for all six -> same codes as the all-equal case.
- Back-to-back runs with different counts -> HC/M cleared at LOAD (cycle 1 of run 2), then updated only at that run's DONE.

Source files
------------

// File: rtl/huffman_code_ctrl_if.sv
// ------------------------------------------------------------------
// huffman_code_ctrl_if: start/count/code bundle for huffman_code_ctrl
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface huffman_code_ctrl_if #(
  parameter int CW = 8
);
  logic          start;
  logic [CW-1:0] CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
  logic          busy;
  logic          code_valid;
  logic [7:0]    HC1, HC2, HC3, HC4, HC5, HC6;
  logic [7:0]    M1, M2, M3, M4, M5, M6;

  modport master (
    output start, CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
    input  busy, code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
    input  M1, M2, M3, M4, M5, M6
  );

  modport slave (
    input  start, CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
    output busy, code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
    output M1, M2, M3, M4, M5, M6
  );
endinterface

`default_nettype wire

// File: rtl/huffman_code_ctrl.sv
// ------------------------------------------------------------------
// huffman_code_ctrl: 5-round Huffman merge sequencer, one group scanned per cycle
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module huffman_code_ctrl #(
  parameter int CW = 8
) (
  input  wire logic            clk,
  input  wire logic            reset,
  huffman_code_ctrl_if.slave   bus
);

  localparam int         WW         = CW + 3;
  localparam int         NS         = 6;
  localparam logic [2:0] LAST_IDX   = 3'd5;
  localparam logic [2:0] LAST_ROUND = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SCAN  = 3'd2,
    MERGE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [2:0]      idx, round;
  logic [WW-1:0]   w   [NS];
  logic [NS-1:0]   active;
  logic [2:0]      g   [NS];
  logic [7:0]      c   [NS];
  logic [2:0]      len [NS];
  logic [2:0]      min1, min2;
  logic [WW-1:0]   min1_w, min2_w;
  logic [7:0]      hc  [NS];
  logic [7:0]      m   [NS];
  logic            code_valid_r;

  logic [CW-1:0]   cnt    [NS];
  logic [7:0]      c_nx   [NS];
  logic [2:0]      len_nx [NS];
  logic [2:0]      g_nx   [NS];
  logic [2:0]      lo_id, hi_id;
  logic [WW-1:0]   w_sum;

  assign cnt[0] = bus.CNT1;
  assign cnt[1] = bus.CNT2;
  assign cnt[2] = bus.CNT3;
  assign cnt[3] = bus.CNT4;
  assign cnt[4] = bus.CNT5;
  assign cnt[5] = bus.CNT6;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = LOAD;
      LOAD:    state_nx = SCAN;
      SCAN:    if (idx == LAST_IDX) state_nx = MERGE;
      MERGE:   state_nx = (round == LAST_ROUND) ? DONE : SCAN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The surviving group keeps the lower id, so a group id is always its lowest member.
  assign lo_id = (min1 < min2) ? min1 : min2;
  assign hi_id = (min1 < min2) ? min2 : min1;
  assign w_sum = w[min1] + w[min2];

  always_comb begin
    for (int n = 0; n < NS; n++) begin
      c_nx[n]   = c[n];
      len_nx[n] = len[n];
      g_nx[n]   = g[n];
      if (g[n] == min1) begin
        c_nx[n]   = c[n] | (8'd1 << len[n]);
        len_nx[n] = len[n] + 3'd1;
        g_nx[n]   = lo_id;
      end else if (g[n] == min2) begin
        len_nx[n] = len[n] + 3'd1;
        g_nx[n]   = lo_id;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx          <= '0;
      round        <= '0;
      active       <= '0;
      min1         <= '0;
      min2         <= '0;
      min1_w       <= '0;
      min2_w       <= '0;
      code_valid_r <= 1'b0;
      for (int n = 0; n < NS; n++) begin
        w[n]   <= '0;
        g[n]   <= '0;
        c[n]   <= '0;
        len[n] <= '0;
        hc[n]  <= '0;
        m[n]   <= '0;
      end
    end else begin
      code_valid_r <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          for (int n = 0; n < NS; n++) begin
            w[n]   <= WW'(cnt[n]);
            g[n]   <= 3'(n);
            c[n]   <= '0;
            len[n] <= '0;
            hc[n]  <= '0;
            m[n]   <= '0;
          end
          active <= '1;
          round  <= '0;
        end
        LOAD: begin
          idx    <= '0;
          min1_w <= '1;
          min2_w <= '1;
        end
        SCAN: begin
          if (active[idx]) begin
            if (w[idx] < min1_w) begin
              min2   <= min1;
              min2_w <= min1_w;
              min1   <= idx;
              min1_w <= w[idx];
            end else if (w[idx] < min2_w) begin
              min2   <= idx;
              min2_w <= w[idx];
            end
          end
          idx <= idx + 3'd1;
        end
        MERGE: begin
          for (int n = 0; n < NS; n++) begin
            c[n]   <= c_nx[n];
            len[n] <= len_nx[n];
            g[n]   <= g_nx[n];
          end
          w[lo_id]      <= w_sum;
          active[hi_id] <= 1'b0;
          round         <= round + 3'd1;
          idx           <= '0;
          min1_w        <= '1;
          min2_w        <= '1;
          // Capture the last merge's result so HC/M and code_valid appear during DONE.
          if (round == LAST_ROUND) begin
            code_valid_r <= 1'b1;
            for (int n = 0; n < NS; n++) begin
              hc[n] <= c_nx[n];
              m[n]  <= (8'd1 << len_nx[n]) - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.code_valid = code_valid_r;
  assign bus.HC1 = hc[0];
  assign bus.HC2 = hc[1];
  assign bus.HC3 = hc[2];
  assign bus.HC4 = hc[3];
  assign bus.HC5 = hc[4];
  assign bus.HC6 = hc[5];
  assign bus.M1  = m[0];
  assign bus.M2  = m[1];
  assign bus.M3  = m[2];
  assign bus.M4  = m[3];
  assign bus.M5  = m[4];
  assign bus.M6  = m[5];

endmodule

`default_nettype wire

// File: tb/tb_huffman_code_ctrl.sv
// ------------------------------------------------------------------
// tb_huffman_code_ctrl: directed runs checked against a member-set Huffman model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_huffman_code_ctrl;

  typedef logic [7:0] vec6_t [6];

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  start = 1'b0;
  vec6_t cur_cnt = '{default: 8'd0};
  int    checks = 0;
  int    failures = 0;
  bit    chk_en = 1'b0;

  always #5 clk = ~clk;

  huffman_code_ctrl_if #(.CW(8)) bus ();

  assign bus.start = start;
  assign bus.CNT1  = cur_cnt[0];
  assign bus.CNT2  = cur_cnt[1];
  assign bus.CNT3  = cur_cnt[2];
  assign bus.CNT4  = cur_cnt[3];
  assign bus.CNT5  = cur_cnt[4];
  assign bus.CNT6  = cur_cnt[5];

  huffman_code_ctrl #(.CW(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Groups are member bitmasks; each round merges the two lightest, ties to lowest member.
  function automatic void huff(input vec6_t cnt, output vec6_t hc, output vec6_t mk);
    int         wt [6];
    logic [5:0] mem [6];
    bit         live [6];
    int         ln [6];
    int         cd [6];
    int         a, b, lo, hi;
    for (int i = 0; i < 6; i++) begin
      wt[i] = int'(cnt[i]); mem[i] = 6'(1 << i); live[i] = 1'b1; ln[i] = 0; cd[i] = 0;
    end
    for (int r = 0; r < 5; r++) begin
      a = -1; b = -1;
      for (int i = 0; i < 6; i++)
        if (live[i] && (a < 0 || wt[i] * 8 + i < wt[a] * 8 + a)) a = i;
      for (int i = 0; i < 6; i++)
        if (live[i] && i != a && (b < 0 || wt[i] * 8 + i < wt[b] * 8 + b)) b = i;
      for (int s = 0; s < 6; s++) begin
        if (mem[a][s]) begin cd[s] += (1 << ln[s]); ln[s]++; end
        if (mem[b][s]) ln[s]++;
      end
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      mem[lo] = mem[a] | mem[b];
      wt[lo]  = wt[a] + wt[b];
      live[hi] = 1'b0;
    end
    for (int s = 0; s < 6; s++) begin
      hc[s] = 8'(cd[s]);
      mk[s] = 8'((1 << ln[s]) - 1);
    end
  endfunction

  // Timing model: k counts cycles since the accepted start (-1 when idle).
  int    k = -1;
  vec6_t exp_hc = '{default: 8'd0};
  vec6_t exp_m  = '{default: 8'd0};
  vec6_t pend_hc, pend_m;
  bit    exp_cv = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = -1; exp_cv = 1'b0;
      exp_hc = '{default: 8'd0}; exp_m = '{default: 8'd0};
    end else begin
      exp_cv = 1'b0;
      if (k < 0) begin
        if (start) begin
          k = 1;
          exp_hc = '{default: 8'd0}; exp_m = '{default: 8'd0};
          huff(cur_cnt, pend_hc, pend_m);
        end
      end else if (k == 37) begin
        k = -1;
      end else begin
        k++;
        if (k == 37) begin exp_hc = pend_hc; exp_m = pend_m; exp_cv = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(bus.busy), int'(k >= 1));
      chk("code_valid", int'(bus.code_valid), int'(exp_cv));
      chk("HC1", bus.HC1, exp_hc[0]); chk("M1", bus.M1, exp_m[0]);
      chk("HC2", bus.HC2, exp_hc[1]); chk("M2", bus.M2, exp_m[1]);
      chk("HC3", bus.HC3, exp_hc[2]); chk("M3", bus.M3, exp_m[2]);
      chk("HC4", bus.HC4, exp_hc[3]); chk("M4", bus.M4, exp_m[3]);
      chk("HC5", bus.HC5, exp_hc[4]); chk("M5", bus.M5, exp_m[4]);
      chk("HC6", bus.HC6, exp_hc[5]); chk("M6", bus.M6, exp_m[5]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic vec6_t dut_hc();
    vec6_t v;
    v[0] = bus.HC1; v[1] = bus.HC2; v[2] = bus.HC3;
    v[3] = bus.HC4; v[4] = bus.HC5; v[5] = bus.HC6;
    return v;
  endfunction

  function automatic vec6_t dut_m();
    vec6_t v;
    v[0] = bus.M1; v[1] = bus.M2; v[2] = bus.M3;
    v[3] = bus.M4; v[4] = bus.M5; v[5] = bus.M6;
    return v;
  endfunction

  // Entered just after an edge with the DUT idle; leaves one cycle after code_valid.
  task automatic run_vec(input string tag, input vec6_t cn, input vec6_t ehc, input vec6_t em);
    int    lat;
    vec6_t h, mm;
    lat = -1;
    cur_cnt = cn;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 60 && lat < 0; cyc++) begin
      @(negedge clk);
      if (bus.code_valid) lat = cyc;
      else tick();
    end
    chk({tag, "_latency"}, lat, 37);
    if (lat >= 0) begin
      h = dut_hc(); mm = dut_m();
      for (int n = 0; n < 6; n++) begin
        chk($sformatf("%s_HC%0d", tag, n + 1), h[n], ehc[n]);
        chk($sformatf("%s_M%0d", tag, n + 1), mm[n], em[n]);
      end
    end
    tick();
  endtask

  vec6_t c_dist, c_ones, c_zmax, c_full;
  vec6_t l_dist_hc, l_dist_m, l_eq_hc, l_eq_m, l_zm_hc, l_zm_m;
  vec6_t mh, mm;
  int    ncv, at37, at75;

  initial begin
    c_dist    = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
    c_ones    = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    c_zmax    = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255};
    c_full    = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    l_dist_hc = '{8'h07, 8'h06, 8'h02, 8'h03, 8'h02, 8'h00};
    l_dist_m  = '{8'h0F, 8'h0F, 8'h07, 8'h03, 8'h03, 8'h03};
    l_eq_hc   = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h03, 8'h02};
    l_eq_m    = '{8'h07, 8'h07, 8'h07, 8'h07, 8'h03, 8'h03};
    l_zm_hc   = '{8'h1F, 8'h1E, 8'h0E, 8'h06, 8'h02, 8'h00};
    l_zm_m    = '{8'h1F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};

    huff(c_dist, mh, mm);
    for (int n = 0; n < 6; n++) begin
      chk($sformatf("model_dist_HC%0d", n + 1), mh[n], l_dist_hc[n]);
      chk($sformatf("model_dist_M%0d", n + 1), mm[n], l_dist_m[n]);
    end

    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_cv", int'(bus.code_valid), 0);
    chk("rst_HC1", bus.HC1, 0);
    chk("rst_M6", bus.M6, 0);
    rst_n = 1'b1;
    tick();

    run_vec("dist", c_dist, l_dist_hc, l_dist_m);
    run_vec("equal", c_ones, l_eq_hc, l_eq_m);
    run_vec("zmax", c_zmax, l_zm_hc, l_zm_m);
    run_vec("full", c_full, l_eq_hc, l_eq_m);

    // start pulses at 0, 5, 37 (one run) and 38 (second run)
    cur_cnt = c_dist;
    ncv = 0; at37 = 0; at75 = 0;
    for (int cyc = 0; cyc <= 80; cyc++) begin
      start = (cyc == 0 || cyc == 5 || cyc == 37 || cyc == 38);
      if (cyc == 38) cur_cnt = c_full;
      @(negedge clk);
      if (bus.code_valid) begin
        ncv++;
        if (cyc == 37) at37 = 1;
        if (cyc == 75) at75 = 1;
      end
      if (cyc == 37) chk("bp_busy37", int'(bus.busy), 1);
      if (cyc == 38) chk("bp_hold_HC1", bus.HC1, 8'h07);
      if (cyc == 39) chk("bp_load_clr_HC1", bus.HC1, 8'h00);
      if (cyc == 75) chk("bp_run2_HC5", bus.HC5, 8'h03);
      tick();
    end
    start = 1'b0;
    chk("bp_cv_count", ncv, 2);
    chk("bp_cv_at37", at37, 1);
    chk("bp_cv_at75", at75, 1);

    // abort a run at cycle 20
    cur_cnt = c_ones;
    ncv = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 20; cyc++) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_HC1", bus.HC1, 0);
    tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (bus.code_valid) ncv++;
      tick();
    end
    chk("abort_no_cv", ncv, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
